mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameters SHALL be: INDEX_WIDTH, default TIA_WORD_WIDTH, MMIO word-index width; DATA_WIDTH, default TIA_WORD_WIDTH, MMIO data width; TIMEOUT_CYCLES, default 1024, maximum cycles a granted transaction may wait for a downstream ack (legal range >= 2).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 hN_read_req / hN_write_req (N=0,1)  in  1 each  host N transaction request, held until the matching ack.
REQ-006 hN_read_index / hN_write_index  in  INDEX_WIDTH each  host N word index.
REQ-007 hN_write_data  in  DATA_WIDTH  host N write data.
REQ-008 hN_read_ack / hN_write_ack  out  1 each  one-cycle completion pulse to host N.
REQ-009 hN_read_data  out  DATA_WIDTH  read data, valid only while hN_read_ack=1, else 0.
REQ-010 d_read_req, d_write_req  out  1 each; d_read_index, d_write_index  out  INDEX_WIDTH each; d_write_data  out  DATA_WIDTH: downstream (system mapper host side) request.
REQ-011 d_read_ack, d_write_ack  in  1 each; d_read_data  in  DATA_WIDTH: downstream completion.
REQ-012 timeout_error  out  1  sticky flag, a transaction timed out.
REQ-013 error_clear  in  1  synchronous clear of timeout_error.

Function
REQ-014 FSM states SHALL be IDLE, READ, WRITE; exactly one downstream transaction outstanding at any time.
REQ-015 In IDLE, a host is pending if its read_req or write_req is 1; if both hosts pending, grant the host not equal to last_grant; if one pending, grant it.
REQ-016 Within the granted host, read SHALL take priority over write when both requests are high.
REQ-017 At grant (IDLE clock edge), index and write data of the granted host SHALL be latched; FSM enters READ or WRITE; last_grant updates to the granted host.
REQ-018 In READ/WRITE, the matching d_*_req SHALL be 1 and d_*_index/d_write_data SHALL drive latched values; the unused downstream channel and all outputs in IDLE drive 0.
REQ-019 Downstream ack SHALL be forwarded combinationally: in the cycle d_read_ack (READ) or d_write_ack (WRITE) is 1, the granted host ack is 1 and hN_read_data = d_read_data; FSM returns to IDLE next edge.
REQ-020 Downstream acks on the channel not in use, or while IDLE, SHALL be ignored.
REQ-021 Minimum latency: host request in cycle T, downstream req in T+1, host ack in T+1 if downstream acks combinationally; one IDLE cycle between consecutive transactions.
REQ-022 Non-granted host outputs SHALL be 0 at all times.
REQ-023 Hosts deassert req in the cycle after ack; a host dropping req while granted does not abort: transaction completes with latched values and ack is still pulsed.
REQ-024 Timeout counter SHALL clear on grant and increment each READ/WRITE cycle; in the cycle it equals TIMEOUT_CYCLES-1 with no downstream ack, host ack pulses with hN_read_data=0, timeout_error sets next edge, FSM returns to IDLE.
REQ-025 Downstream ack in the timeout cycle SHALL win: normal completion, no error.
REQ-026 error_clear and a timeout in the same cycle: timeout_error SHALL remain 1.

Reset
REQ-027 While reset_n=0: state IDLE, last_grant=1 (host 0 wins first tie), timeout counter 0, latched index/data 0, timeout_error 0, all outputs 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it immediately with no ack to any host; a late downstream ack after reset is ignored.

Verification
REQ-029 Host 0 read index 0x40000003, downstream acks 2 cycles after d_read_req with data 0xDEADBEEF -> d_read_index=0x40000003, h0_read_ack one cycle with h0_read_data=0xDEADBEEF.
REQ-030 Both hosts write continuously after reset -> grants alternate h0,h1,h0,h1; each d_write_data matches granting host; no ack to wrong host.
REQ-031 Host 1 raises read and write together -> read completes first, write granted after one IDLE cycle.
REQ-032 TIMEOUT_CYCLES=8, downstream never acks -> host ack after 8 READ cycles, read_data 0, timeout_error=1; error_clear pulse -> 0.
REQ-033 Downstream ack exactly in the 8th cycle -> normal completion, timeout_error stays 0.
REQ-034 reset_n pulsed low during WRITE -> all outputs 0 immediately; after release, h0 wins a simultaneous h0/h1 request.

Source files
------------

// File: rtl/mmio_arbiter_if.sv
// MMIO request/ack bundle shared by the two host ports and the downstream port.
// master drives requests and consumes acks; slave is the opposite side.
interface mmio_arbiter_if #(
  parameter int unsigned INDEX_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic                   read_req;
  logic [INDEX_WIDTH-1:0] read_index;
  logic                   read_ack;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   write_req;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   write_ack;

  modport master (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );

  modport slave (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-host MMIO arbiter: round-robin grant, one outstanding downstream transaction,
// combinational ack forwarding and a per-transaction timeout with sticky error flag.
module mmio_arbiter #(
  parameter int unsigned INDEX_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset_n,
  mmio_arbiter_if.slave   h0,
  mmio_arbiter_if.slave   h1,
  mmio_arbiter_if.master  d,
  output logic            timeout_error,
  input  logic            error_clear
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_last_grant;
  logic                   w_last_grant_nxt;
  logic                   r_grant;
  logic                   w_grant_nxt;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [INDEX_WIDTH-1:0] w_index_nxt;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  w_wdata_nxt;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic                   r_timeout_error;
  logic                   w_timeout_error_nxt;

  logic                   w_pend0;
  logic                   w_pend1;
  logic                   w_sel;
  logic                   w_sel_rd;
  logic [INDEX_WIDTH-1:0] w_sel_ridx;
  logic [INDEX_WIDTH-1:0] w_sel_widx;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_expire;
  logic                   w_finish;
  logic                   w_rd_ack;
  logic                   w_wr_ack;
  logic [DATA_WIDTH-1:0]  w_rdata;

  // State and latched-transaction registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_last_grant    <= 1'b1;
      r_grant         <= 1'b0;
      r_index         <= '0;
      r_wdata         <= '0;
      r_timer         <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_last_grant    <= w_last_grant_nxt;
      r_grant         <= w_grant_nxt;
      r_index         <= w_index_nxt;
      r_wdata         <= w_wdata_nxt;
      r_timer         <= w_timer_nxt;
      r_timeout_error <= w_timeout_error_nxt;
    end
  end

  // Arbitration, downstream drive, ack forwarding and timeout
  always_comb begin
    w_state_nxt         = r_state;
    w_last_grant_nxt    = r_last_grant;
    w_grant_nxt         = r_grant;
    w_index_nxt         = r_index;
    w_wdata_nxt         = r_wdata;
    w_timer_nxt         = r_timer;
    w_timeout_error_nxt = r_timeout_error;
    w_done              = 1'b0;
    w_expire            = 1'b0;
    w_finish            = 1'b0;
    w_rd_ack            = 1'b0;
    w_wr_ack            = 1'b0;
    w_rdata             = '0;

    d.read_req    = 1'b0;
    d.read_index  = '0;
    d.write_req   = 1'b0;
    d.write_index = '0;
    d.write_data  = '0;
    h0.read_ack   = 1'b0;
    h0.write_ack  = 1'b0;
    h0.read_data  = '0;
    h1.read_ack   = 1'b0;
    h1.write_ack  = 1'b0;
    h1.read_data  = '0;

    w_pend0 = h0.read_req | h0.write_req;
    w_pend1 = h1.read_req | h1.write_req;
    // On a tie the host that did not win last time gets the grant
    if (w_pend0 && w_pend1) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = w_pend1;
    end
    w_sel_rd    = w_sel ? h1.read_req    : h0.read_req;
    w_sel_ridx  = w_sel ? h1.read_index  : h0.read_index;
    w_sel_widx  = w_sel ? h1.write_index : h0.write_index;
    w_sel_wdata = w_sel ? h1.write_data  : h0.write_data;

    w_busy = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_pend0 || w_pend1) begin
          w_grant_nxt      = w_sel;
          w_last_grant_nxt = w_sel;
          w_timer_nxt      = '0;
          w_wdata_nxt      = w_sel_wdata;
          if (w_sel_rd) begin
            w_state_nxt = READ;
            w_index_nxt = w_sel_ridx;
          end else begin
            w_state_nxt = WRITE;
            w_index_nxt = w_sel_widx;
          end
        end
      end
      READ: begin
        d.read_req   = 1'b1;
        d.read_index = r_index;
        w_done       = d.read_ack;
      end
      WRITE: begin
        d.write_req   = 1'b1;
        d.write_index = r_index;
        d.write_data  = r_wdata;
        w_done        = d.write_ack;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A downstream ack in the final cycle counts as a normal completion
    w_expire = w_busy && !w_done && (r_timer == TMAX);
    w_finish = w_done || w_expire;

    if (w_busy) begin
      w_timer_nxt = r_timer + TW'(1);
      if (w_finish) begin
        w_state_nxt = IDLE;
      end
    end

    w_rd_ack = (r_state == READ)  && w_finish;
    w_wr_ack = (r_state == WRITE) && w_finish;
    if ((r_state == READ) && w_done) begin
      w_rdata = d.read_data;
    end

    if (!r_grant) begin
      h0.read_ack  = w_rd_ack;
      h0.write_ack = w_wr_ack;
      h0.read_data = w_rdata;
    end else begin
      h1.read_ack  = w_rd_ack;
      h1.write_ack = w_wr_ack;
      h1.read_data = w_rdata;
    end

    // A timeout in the same cycle as error_clear keeps the flag set
    if (w_expire) begin
      w_timeout_error_nxt = 1'b1;
    end else if (error_clear) begin
      w_timeout_error_nxt = 1'b0;
    end
  end

  assign timeout_error = r_timeout_error;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: directed host transactions push expected
// downstream requests and host acks; a negedge monitor pops and compares them.
module tb_mmio_arbiter;

  logic clk;
  logic rst_n;
  logic timeout_error;
  logic error_clear;

  mmio_arbiter_if #(.INDEX_WIDTH(32), .DATA_WIDTH(32)) h0_if ();
  mmio_arbiter_if #(.INDEX_WIDTH(32), .DATA_WIDTH(32)) h1_if ();
  mmio_arbiter_if #(.INDEX_WIDTH(32), .DATA_WIDTH(32)) d_if ();

  mmio_arbiter #(
    .INDEX_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .h0(h0_if),
    .h1(h1_if),
    .d(d_if),
    .timeout_error(timeout_error),
    .error_clear(error_clear)
  );

  typedef struct {
    bit          rd;
    logic [31:0] idx;
    logic [31:0] wd;
  } dexp_t;

  typedef struct {
    int          host;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } hexp_t;

  dexp_t exp_d[$];
  hexp_t exp_h[$];

  int n_tests = 0;
  int n_fail  = 0;

  int          resp_lat    = 0;
  bit          resp_never  = 0;
  bit          stray_idle  = 0;
  bit          stray_wrong = 0;
  logic [31:0] resp_data   = 32'h0;
  int          resp_cyc    = 0;

  bit    mon_prev_busy = 0;
  int    mon_cyc       = 0;
  dexp_t mon_cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_d(input bit rd, input logic [31:0] idx, input logic [31:0] wd);
    dexp_t e;
    e.rd = rd; e.idx = idx; e.wd = wd;
    exp_d.push_back(e);
  endtask

  task automatic push_h(input int h, input bit rd, input logic [31:0] data, input int cyc);
    hexp_t e;
    e.host = h; e.rd = rd; e.data = data; e.cyc = cyc;
    exp_h.push_back(e);
  endtask

  task automatic set_rd(input int h, input bit v);
    if (h == 0) h0_if.read_req = v; else h1_if.read_req = v;
  endtask

  task automatic set_wr(input int h, input bit v);
    if (h == 0) h0_if.write_req = v; else h1_if.write_req = v;
  endtask

  task automatic set_payload(input int h, input logic [31:0] ridx, input logic [31:0] widx,
                             input logic [31:0] wd);
    if (h == 0) begin
      h0_if.read_index = ridx; h0_if.write_index = widx; h0_if.write_data = wd;
    end else begin
      h1_if.read_index = ridx; h1_if.write_index = widx; h1_if.write_data = wd;
    end
  endtask

  function automatic bit get_rack(input int h);
    return (h == 0) ? h0_if.read_ack : h1_if.read_ack;
  endfunction

  function automatic bit get_wack(input int h);
    return (h == 0) ? h0_if.write_ack : h1_if.write_ack;
  endfunction

  // Host agent: hold each request until its ack, drop it the cycle after
  task automatic host_txn(input int h, input bit do_rd, input bit do_wr,
                          input logic [31:0] ridx, input logic [31:0] widx,
                          input logic [31:0] wd);
    bit rd_p, wr_p, rd_s, wr_s;
    int n;
    rd_p = do_rd; wr_p = do_wr; n = 0;
    @(posedge clk); #1;
    set_payload(h, ridx, widx, wd);
    set_rd(h, do_rd);
    set_wr(h, do_wr);
    while ((rd_p || wr_p) && n < 200) begin
      @(negedge clk);
      n++;
      rd_s = rd_p && get_rack(h);
      wr_s = wr_p && get_wack(h);
      @(posedge clk); #1;
      if (rd_s) begin set_rd(h, 1'b0); rd_p = 0; end
      if (wr_s) begin set_wr(h, 1'b0); wr_p = 0; end
    end
    n_tests++;
    if (rd_p || wr_p) begin
      n_fail++;
      $display("FAIL host%0d_ack_wait: no ack after %0d cycles, ack required", h, n);
      set_rd(h, 1'b0);
      set_wr(h, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_dreq(input bit rd, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (rd ? d_if.read_req : d_if.write_req) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL dreq_wait: downstream req not seen, required within 50 cycles");
    end
  endtask

  task automatic wait_hack(input int h, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_rack(h) || get_wack(h)) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hack_wait: host%0d ack not seen, required within 50 cycles", h);
    end
  endtask

  task automatic chk_outputs_zero();
    chk("rst_d_req", 32'({d_if.read_req, d_if.write_req}), 32'h0);
    chk("rst_d_index", d_if.read_index | d_if.write_index, 32'h0);
    chk("rst_d_wdata", d_if.write_data, 32'h0);
    chk("rst_h_ack", 32'({h0_if.read_ack, h0_if.write_ack, h1_if.read_ack, h1_if.write_ack}),
        32'h0);
    chk("rst_h_rdata", h0_if.read_data | h1_if.read_data, 32'h0);
    chk("rst_timeout_error", 32'(timeout_error), 32'h0);
  endtask

  // Downstream responder: ack after resp_lat idle cycles, plus optional stray acks
  always @(posedge clk) begin
    #1;
    d_if.read_data = resp_data;
    if (d_if.read_req || d_if.write_req) begin
      resp_cyc++;
      d_if.read_ack  = d_if.read_req && !resp_never && (resp_cyc == resp_lat + 1);
      d_if.write_ack = (d_if.write_req && !resp_never && (resp_cyc == resp_lat + 1)) ||
                       (stray_wrong && d_if.read_req);
    end else begin
      resp_cyc       = 0;
      d_if.read_ack  = stray_idle;
      d_if.write_ack = stray_idle;
    end
  end

  // Monitor: compare downstream requests and host acks against the queues
  always @(negedge clk) begin
    bit   busy;
    int   nack;
    int   host;
    bit   rd;
    hexp_t e;
    busy = d_if.read_req || d_if.write_req;
    if (busy) begin
      if (!mon_prev_busy) begin
        mon_cyc = 1;
        if (exp_d.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d_unexpected: downstream req with index %h, none expected",
                   d_if.read_req ? d_if.read_index : d_if.write_index);
        end else begin
          mon_cur = exp_d.pop_front();
          chk("d_kind", 32'(d_if.read_req), 32'(mon_cur.rd));
          chk("d_index", mon_cur.rd ? d_if.read_index : d_if.write_index, mon_cur.idx);
          chk("d_unused_zero", mon_cur.rd ? (d_if.write_index | d_if.write_data) : d_if.read_index,
              32'h0);
          if (!mon_cur.rd) chk("d_wdata", d_if.write_data, mon_cur.wd);
        end
      end else begin
        mon_cyc++;
      end
    end else begin
      chk("d_idle_zero", d_if.read_index | d_if.write_index | d_if.write_data, 32'h0);
    end
    mon_prev_busy = busy;

    if (!h0_if.read_ack) chk("h0_rdata_zero", h0_if.read_data, 32'h0);
    if (!h1_if.read_ack) chk("h1_rdata_zero", h1_if.read_data, 32'h0);

    nack = int'(h0_if.read_ack) + int'(h0_if.write_ack) + int'(h1_if.read_ack) +
           int'(h1_if.write_ack);
    if (nack != 0) begin
      chk("ack_onehot", 32'(nack), 32'd1);
      host = (h1_if.read_ack || h1_if.write_ack) ? 1 : 0;
      rd   = h0_if.read_ack || h1_if.read_ack;
      if (exp_h.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL h_unexpected: ack to host%0d, none expected", host);
      end else begin
        e = exp_h.pop_front();
        chk("ack_host", 32'(host), 32'(e.host));
        chk("ack_kind", 32'(rd), 32'(e.rd));
        chk("ack_rdata", host ? h1_if.read_data : h0_if.read_data, e.data);
        chk("ack_latency", 32'(mon_cyc), 32'(e.cyc));
        if (busy) chk("d_index_hold", mon_cur.rd ? d_if.read_index : d_if.write_index, mon_cur.idx);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    error_clear = 1'b0;
    h0_if.read_req = 0; h0_if.write_req = 0;
    h1_if.read_req = 0; h1_if.write_req = 0;
    set_payload(0, 32'h0, 32'h0, 32'h0);
    set_payload(1, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both hosts writing back-to-back: h0 first, then strict alternation
    resp_lat = 0;
    for (int k = 0; k < 3; k++) begin
      push_d(0, 32'h100 + 32'(k), 32'hA000_0000 + 32'(k));
      push_h(0, 0, 32'h0, 1);
      push_d(0, 32'h200 + 32'(k), 32'hB000_0000 + 32'(k));
      push_h(1, 0, 32'h0, 1);
    end
    fork
      for (int k = 0; k < 3; k++) host_txn(0, 0, 1, 32'h0, 32'h100 + 32'(k), 32'hA000_0000 + 32'(k));
      for (int k = 0; k < 3; k++) host_txn(1, 0, 1, 32'h0, 32'h200 + 32'(k), 32'hB000_0000 + 32'(k));
    join

    // Host 0 read, downstream acks two cycles after the request
    resp_lat = 2;
    resp_data = 32'hDEAD_BEEF;
    push_d(1, 32'h4000_0003, 32'h0);
    push_h(0, 1, 32'hDEAD_BEEF, 3);
    host_txn(0, 1, 0, 32'h4000_0003, 32'h0, 32'h0);

    // Host 1 read and write together: read first, write after an idle cycle
    resp_lat = 1;
    resp_data = 32'h1234_5678;
    push_d(1, 32'h11, 32'h0);
    push_h(1, 1, 32'h1234_5678, 2);
    push_d(0, 32'h22, 32'h33);
    push_h(1, 0, 32'h0, 2);
    host_txn(1, 1, 1, 32'h11, 32'h22, 32'h33);

    // Host drops its request mid-transaction: latched index kept, ack still given
    resp_lat = 3;
    resp_data = 32'hCAFE_F00D;
    push_d(1, 32'h55, 32'h0);
    push_h(0, 1, 32'hCAFE_F00D, 4);
    @(posedge clk); #1;
    h0_if.read_index = 32'h55;
    h0_if.read_req = 1;
    wait_dreq(1, ok);
    h0_if.read_req = 0;
    h0_if.read_index = 32'h99;
    wait_hack(0, ok);
    @(posedge clk); #1;

    // Stray acks while idle and on the unused channel are ignored
    stray_idle = 1;
    repeat (3) begin @(posedge clk); #1; end
    stray_wrong = 1;
    resp_lat = 2;
    resp_data = 32'h0BAD_CAFE;
    push_d(1, 32'h13, 32'h0);
    push_h(1, 1, 32'h0BAD_CAFE, 3);
    host_txn(1, 1, 0, 32'h13, 32'h0, 32'h0);
    stray_idle = 0;
    stray_wrong = 0;

    // Downstream never acks: timeout in cycle 8 with zero data
    resp_never = 1;
    resp_data = 32'hFFFF_FFFF;
    push_d(1, 32'h77, 32'h0);
    push_h(0, 1, 32'h0, 8);
    host_txn(0, 1, 0, 32'h77, 32'h0, 32'h0);
    chk("timeout_error_set", 32'(timeout_error), 32'h1);
    error_clear = 1;
    @(posedge clk); #1;
    error_clear = 0;
    chk("timeout_error_cleared", 32'(timeout_error), 32'h0);

    // Ack exactly in the last allowed cycle wins over the timeout
    resp_never = 0;
    resp_lat = 7;
    resp_data = 32'h600D_D00D;
    push_d(1, 32'h78, 32'h0);
    push_h(1, 1, 32'h600D_D00D, 8);
    host_txn(1, 1, 0, 32'h78, 32'h0, 32'h0);
    chk("no_timeout_on_last_ack", 32'(timeout_error), 32'h0);

    // error_clear in the timeout cycle loses to the new timeout
    resp_never = 1;
    push_d(0, 32'h88, 32'h99);
    push_h(1, 0, 32'h0, 8);
    fork
      host_txn(1, 0, 1, 32'h0, 32'h88, 32'h99);
      begin
        wait_dreq(0, ok);
        repeat (7) begin @(posedge clk); #1; end
        error_clear = 1;
        @(posedge clk); #1;
        error_clear = 0;
        @(negedge clk);
        chk("timeout_set_beats_clear", 32'(timeout_error), 32'h1);
      end
    join
    error_clear = 1;
    @(posedge clk); #1;
    error_clear = 0;
    chk("timeout_error_cleared2", 32'(timeout_error), 32'h0);

    // Reset during WRITE abandons it; afterwards h0 wins a tie again
    push_d(0, 32'h44, 32'h45);
    @(posedge clk); #1;
    h0_if.write_index = 32'h44;
    h0_if.write_data = 32'h45;
    h0_if.write_req = 1;
    wait_dreq(0, ok);
    @(posedge clk); #3;
    rst_n = 0;
    stray_idle = 1;
    #1;
    chk_outputs_zero();
    h0_if.write_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) begin @(posedge clk); #1; end
    stray_idle = 0;
    resp_never = 0;
    resp_lat = 0;
    resp_data = 32'h5A5A_5A5A;
    push_d(1, 32'h61, 32'h0);
    push_h(0, 1, 32'h5A5A_5A5A, 1);
    push_d(1, 32'h62, 32'h0);
    push_h(1, 1, 32'h5A5A_5A5A, 1);
    fork
      host_txn(0, 1, 0, 32'h61, 32'h0, 32'h0);
      host_txn(1, 1, 0, 32'h62, 32'h0, 32'h0);
    join

    repeat (5) @(posedge clk);
    #1;
    chk("exp_d_drained", 32'(exp_d.size()), 32'h0);
    chk("exp_h_drained", 32'(exp_h.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
